// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - two-requester RAM port bundle plus RAM-side signals
interface ram_port_arbiter_if #(
    parameter int addr_width = 8
);
    logic                  m0_req;
    logic                  m0_gnt;
    logic [addr_width-1:0] m0_addr;
    logic [7:0]            m0_wdata;
    logic                  m0_wen;

    logic                  m1_req;
    logic                  m1_gnt;
    logic [addr_width-1:0] m1_addr;
    logic [7:0]            m1_wdata;
    logic                  m1_wen;

    logic [7:0]            rd_data;
    logic [addr_width-1:0] ram_addr;
    logic [7:0]            ram_wdata;
    logic                  ram_wen;
    logic [7:0]            ram_rdata;

    // Arbiter view: requests and RAM read data in, grants and RAM controls out.
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wen,
        input  m1_req, m1_addr, m1_wdata, m1_wen,
        input  ram_rdata,
        output m0_gnt, m1_gnt, rd_data,
        output ram_addr, ram_wdata, ram_wen
    );

    // Requesters and RAM view.
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wen,
        output m1_req, m1_addr, m1_wdata, m1_wen,
        output ram_rdata,
        input  m0_gnt, m1_gnt, rd_data,
        input  ram_addr, ram_wdata, ram_wen
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port arbiter for a single-port byte RAM
module ram_port_arbiter #(
    parameter int addr_width = 8,
    parameter int max_burst  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] burst_last = 8'(max_burst - 1);

    state_t                state;
    state_t                state_next;
    logic [7:0]            burst_cnt;
    logic [7:0]            burst_cnt_next;
    logic                  last_served;
    logic                  last_served_next;

    logic                  gnt0;
    logic                  gnt1;
    logic [addr_width-1:0] mux_addr;
    logic [7:0]            mux_wdata;
    logic                  mux_wen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            burst_cnt   <= 8'd0;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            burst_cnt   <= burst_cnt_next;
            last_served <= last_served_next;
        end
    end

    // Release hands straight to a waiting peer; a held grant is pre-empted only at the burst limit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req)
                    state_next = last_served ? OWN0 : OWN1;
                else if (bus.m0_req)
                    state_next = OWN0;
                else if (bus.m1_req)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!bus.m0_req)
                    state_next = bus.m1_req ? OWN1 : IDLE;
                else if (bus.m1_req && (burst_cnt == burst_last))
                    state_next = OWN1;
            end
            OWN1: begin
                if (!bus.m1_req)
                    state_next = bus.m0_req ? OWN0 : IDLE;
                else if (bus.m0_req && (burst_cnt == burst_last))
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        burst_cnt_next   = burst_cnt;
        last_served_next = last_served;
        if ((state_next != state) || (state_next == IDLE))
            burst_cnt_next = 8'd0;
        else if (burst_cnt != burst_last)
            burst_cnt_next = burst_cnt + 8'd1;
        if ((state_next == OWN0) && (state != OWN0))
            last_served_next = 1'b0;
        else if ((state_next == OWN1) && (state != OWN1))
            last_served_next = 1'b1;
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mux_addr  = '0;
        mux_wdata = 8'd0;
        mux_wen   = 1'b0;
        case (state)
            OWN0: begin
                gnt0      = 1'b1;
                mux_addr  = bus.m0_addr;
                mux_wdata = bus.m0_wdata;
                mux_wen   = bus.m0_wen & bus.m0_req;
            end
            OWN1: begin
                gnt1      = 1'b1;
                mux_addr  = bus.m1_addr;
                mux_wdata = bus.m1_wdata;
                mux_wen   = bus.m1_wen & bus.m1_req;
            end
            default: begin
                gnt0 = 1'b0;
            end
        endcase
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.ram_addr  = mux_addr;
    assign bus.ram_wdata = mux_wdata;
    assign bus.ram_wen   = mux_wen;
    assign bus.rd_data   = bus.ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural arbitration model
module tb_ram_port_arbiter;
    localparam int MB = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.addr_width(8)) bus ();

    ram_port_arbiter #(.addr_width(8), .max_burst(MB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // RAM behind the arbiter: synchronous read-before-write byte array.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;

    function automatic logic [7:0] init_val(int i);
        if (i == 3) return 8'hA5;
        return 8'((i * 29) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.ram_wen) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct {
        logic       g0;
        logic       g1;
        logic       wen;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rd_chk;
        logic [7:0] rd;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner -1 = free, run = cycles the current owner has held the RAM.
    int         owner = -1;
    int         run   = 0;
    int         last  = 1;
    logic [7:0] ref_mem [256];
    logic       rd_chk_n = 1'b0;
    logic [7:0] rd_exp_n = 8'h00;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic cycle(input bit rst,
                         input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                         input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
        exp_t       e;
        bit         rq [2];
        bit         wq [2];
        logic [7:0] aq [2];
        logic [7:0] dq [2];
        int         nxt;
        rst_n        = rst;
        bus.m0_req   = r0; bus.m0_wen = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req   = r1; bus.m1_wen = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        rq[0] = r0; wq[0] = w0; aq[0] = a0; dq[0] = d0;
        rq[1] = r1; wq[1] = w1; aq[1] = a1; dq[1] = d1;
        e.g0     = (owner == 0);
        e.g1     = (owner == 1);
        e.addr   = (owner >= 0) ? aq[owner] : 8'h00;
        e.wdata  = (owner >= 0) ? dq[owner] : 8'h00;
        e.wen    = (owner >= 0) && rq[owner] && wq[owner];
        e.rd_chk = rd_chk_n;
        e.rd     = rd_exp_n;
        expq.push_back(e);
        @(posedge clk);
        rd_chk_n = (owner >= 0);
        rd_exp_n = ref_mem[e.addr];
        if (e.wen) ref_mem[e.addr] = e.wdata;
        if (!rst) begin
            owner = -1; run = 0; last = 1;
        end else begin
            if (owner < 0)
                nxt = (rq[0] && rq[1]) ? ((last == 1) ? 0 : 1) : (rq[0] ? 0 : (rq[1] ? 1 : -1));
            else if (!rq[owner])
                nxt = rq[1 - owner] ? 1 - owner : -1;
            else if (rq[1 - owner] && run >= MB)
                nxt = 1 - owner;
            else
                nxt = owner;
            if (nxt != owner) begin
                run   = (nxt < 0) ? 0 : 1;
                if (nxt >= 0) last = nxt;
                owner = nxt;
            end else if (owner >= 0) begin
                run++;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rst, input int n);
        for (int i = 0; i < n; i++) cycle(rst, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                m = expq.pop_front();
                check("m0_gnt", {7'd0, bus.m0_gnt}, {7'd0, m.g0});
                check("m1_gnt", {7'd0, bus.m1_gnt}, {7'd0, m.g1});
                check("ram_wen", {7'd0, bus.ram_wen}, {7'd0, m.wen});
                check("ram_addr", bus.ram_addr, m.addr);
                check("ram_wdata", bus.ram_wdata, m.wdata);
                if (m.rd_chk) check("rd_data", bus.rd_data, m.rd);
            end
        end
    end

    initial begin : stimulus
        bit r0, r1;
        int flip;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m0_wen = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_wen = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        @(posedge clk);
        #1;

        // Single requester: write 0x11 to 0x05, read 0x03, then hand over during the read.
        idle(0, 2);
        idle(1, 1);
        cycle(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(1, 1, 1, 8'h05, 8'h11, 0, 0, 8'h00, 8'h00);
        cycle(1, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(1, 1, 0, 8'h03, 8'h00, 1, 0, 8'h40, 8'h00);
        cycle(1, 0, 0, 8'h03, 8'h00, 1, 0, 8'h41, 8'h00);
        cycle(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h42, 8'h00);
        idle(1, 2);

        // Tie after reset, release with no dead cycle, re-tie goes back to port 0.
        idle(0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 8'(i), 8'h00, 1, 0, 8'h30, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'(8'h31 + i), 8'h00);
        idle(1, 2);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'h07, 8'h00, 1, 0, 8'h08, 8'h00);
        idle(1, 2);

        // Burst limit both ways; port 1 keeps writing 0x10 while port 0 owns.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h3C);
        for (int i = 0; i < 80; i++)
            cycle(1, 1, 0, 8'($urandom_range(0, 255)), 8'h00,
                  1, 1, 8'h10, (owner == 1) ? 8'h3C : 8'hC3);
        idle(1, 2);
        check("addr10_kept", mem[8'h10], 8'h3C);

        // Reset in the middle of a port 1 write burst.
        idle(0, 1);
        cycle(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h0F, 8'h00);
        for (int i = 0; i < 16; i++)
            cycle((i == 4 || i == 5) ? 1'b0 : 1'b1, (i >= 6), 0, 8'h03, 8'h00,
                  1, 1, 8'(8'h10 + i), 8'(8'h80 + i));
        idle(1, 2);
        check("addr14_written", mem[8'h14], 8'h84);
        for (int i = 8'h15; i <= 8'h1F; i++) check("post_reset_untouched", mem[i], init_val(i));

        // Randomized traffic with sticky requests and occasional resets.
        r0 = 0; r1 = 0;
        for (int seg = 0; seg < 4; seg++) begin
            flip = (seg % 2 == 1) ? 40 : 4;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, flip - 1) == 0) r0 = ~r0;
                if ($urandom_range(0, flip - 1) == 0) r1 = ~r1;
                cycle(($urandom_range(0, 299) != 0),
                      r0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      r1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
        end
        idle(1, 2);

        @(negedge clk);
        check("queue_drained", 8'(expq.size()), 8'd0);
        for (int i = 0; i < 256; i++) check("ram_contents", mem[i], ref_mem[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port byte RAM between two requesters: port 0, the QSPI host-side loader, and port 1, the byte-processing engine that reads a block, transforms it and writes results back.
- Uses a req/gnt handshake with a registered grant, round-robin fairness and a burst limit that forces hand-over.
- Mux of address, write data and write enable is combinational from the registered grant; read data is broadcast to both ports.

Parameters:
- addr_width, 8, RAM address width.
- max_burst, 32, maximum consecutive granted cycles while the other port is waiting. Legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- m0_req  input  1  port 0 requests RAM
- m0_gnt  output  1  port 0 owns RAM (registered)
- m0_addr  input  addr_width  port 0 address
- m0_wdata  input  8  port 0 write data
- m0_wen  input  1  port 0 write enable
- m1_req, m1_gnt, m1_addr, m1_wdata, m1_wen: same as port 0, for port 1
- rd_data  output  8  RAM read data, broadcast to both ports
- ram_addr  output  addr_width  RAM address
- ram_wdata  output  8  RAM write data
- ram_wen  output  1  RAM write enable
- ram_rdata  input  8  RAM synchronous read data

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low (clk, rst_n). All registers update only on posedge clk.
  - While rst_n=0 at an edge: state=IDLE, m0_gnt=0, m1_gnt=0, burst counter=0, last-served pointer=1, so port 0 wins the first tie.
- State machine: IDLE, OWN0, OWN1. m0_gnt=(state==OWN0) and m1_gnt=(state==OWN1), both decoded from the state register. The two grants are never high together.
- IDLE:
  - Only m0_req → OWN0. Only m1_req → OWN1.
  - Both requesting → the port not equal to last-served. Neither → stay IDLE.
- OWNx:
  - If the owner drops req, the grant transfers at the next edge: directly to the other port if it is requesting, else to IDLE. There is no dead cycle between owners.
  - If the owner holds req, the other port requests, and burst counter == max_burst-1, the next edge forces the grant to the other port. The pre-empted port stays requesting and is re-served later by round-robin.
  - If the owner holds req and the other port is idle, the owner keeps the grant indefinitely. The counter saturates at max_burst-1.
- Burst counter:
  - Cleared on every grant change and in IDLE.
  - Increments each cycle a grant is held.
- Last-served pointer: updated to x on every entry into OWNx.
- Latency:
  - A req seen at edge k with the RAM free gives gnt high after edge k, a 1-cycle request-to-grant.
  - A requester may drive addr/wen in the cycle gnt is high; the access happens that cycle.
- Mux:
  - In OWNx, ram_addr/ram_wdata take mx_addr/mx_wdata, and ram_wen = mx_wen & mx_req.
  - In IDLE, ram_addr=0, ram_wdata=0, ram_wen=0.
  - A wen from a non-granted port never reaches the RAM.
- Read data:
  - rd_data = ram_rdata, passed through unregistered.
  - It is valid one cycle after the address cycle. Each requester qualifies it with its own delayed gnt.
  - After a hand-over, the first-cycle rd_data belongs to the previous owner's address.
- Reset mid-operation: the grant drops at the reset edge and ram_wen=0 from then on. No write is issued in the reset cycle after the edge.
- Simultaneous events: the owner dropping req in the same cycle the burst limit is reached is handled as a normal release. A new request arriving in the same cycle another request is released is handled by the normal transfer rule.

Test Plan:
- Reset, then m0_req=1 at cycle 2 with m1 idle → m0_gnt=1 from cycle 3; ram_addr follows m0_addr. Write 0x11 to addr 0x05 → ram_wen=1 for exactly that cycle.
- Both req asserted together straight after reset → port 0 granted first. Port 0 drops req after 4 cycles → m1_gnt=1 on the next edge, no IDLE cycle. Both then re-request after idling → port 0 granted again (last-served=1).
- Port 1 holds req continuously and port 0 requests; with max_burst=32 → port 1 owns exactly 32 cycles, then m0_gnt=1. Port 0 holds 32 cycles → grant returns to port 1.
- m1_wen=1 with m1_addr=0x10 while port 0 owns → ram_wen reflects only m0_wen; RAM contents at 0x10 unchanged (checked by scoreboard model).
- Reset pulsed mid-write burst of port 1 (addr 0x10..0x1F, reset at 0x14) → gnts 0 and ram_wen 0 after the reset edge; 0x15..0x1F unchanged. After release, port 0 wins a tie.
- Read: port 0 reads addr 0x03 holding 0xA5 → rd_data=0xA5 one cycle after the address cycle. Hand-over in that cycle → rd_data still 0xA5 for the old owner's read.
